// File: rtl/vedic_pkg.sv
// ----------------------------------------------------------------------------
// vedic_pkg
// Shared constants and types for the Vedic multiplier and the MAC stage
// built on top of it.
//   OP_W   : operand width of the multiplier (4)
//   PROD_W : full product width (2*OP_W = 8)
// ----------------------------------------------------------------------------
package vedic_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 2 * OP_W;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

    // 2x2 Vedic (Urdhva Tiryagbhyam) block: vertical, crosswise, vertical.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic v0;
        logic cross_a;
        logic cross_b;
        logic c1;
        logic v1;
        logic [3:0] r;
        v0      = x[0] & y[0];
        cross_a = x[1] & y[0];
        cross_b = x[0] & y[1];
        c1      = cross_a & cross_b;
        v1      = x[1] & y[1];
        r[0]    = v0;
        r[1]    = cross_a ^ cross_b;
        r[2]    = v1 ^ c1;
        r[3]    = v1 & c1;
        return r;
    endfunction

endpackage

// File: rtl/vedic_mac4_mult.sv
// ----------------------------------------------------------------------------
// multiplier4x4
// Combinational 4x4 unsigned Vedic multiplier. The operands are split into
// 2-bit halves, four 2x2 Vedic blocks form the partial products, and these
// are recombined with their weights (1, 4, 4, 16).
// Only N = 4 is implemented; the parameter exists so instantiations state
// the width they rely on.
// Ports:
//   a  in  N    multiplicand, unsigned
//   b  in  N    multiplier, unsigned
//   p  out 2N   product a*b
// ----------------------------------------------------------------------------
module multiplier4x4
    import vedic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [3:0] q_ll;   // a_lo * b_lo, weight 1
    logic [3:0] q_hl;   // a_hi * b_lo, weight 4
    logic [3:0] q_lh;   // a_lo * b_hi, weight 4
    logic [3:0] q_hh;   // a_hi * b_hi, weight 16
    logic [4:0] cross_sum;

    always_comb begin
        q_ll = vedic2x2(a[1:0], b[1:0]);
        q_hl = vedic2x2(a[3:2], b[1:0]);
        q_lh = vedic2x2(a[1:0], b[3:2]);
        q_hh = vedic2x2(a[3:2], b[3:2]);
    end

    // The two crosswise terms share a weight, so add them once first.
    assign cross_sum = {1'b0, q_hl} + {1'b0, q_lh};

    // Max result 225 fits in 8 bits, so no carry out of the top is dropped.
    assign p = {4'b0000, q_ll}
             + {1'b0, cross_sum, 2'b00}
             + {q_hh, 4'b0000};

endmodule

// File: rtl/vedic_mac4.sv
// ----------------------------------------------------------------------------
// vedic_mac4
// Streaming multiply-accumulate stage. 4-bit operand pairs are multiplied by
// the Vedic 4x4 multiplier, the product is registered (S1), then summed into
// a group accumulator (S2). When the group's last term reaches S2 the total,
// term count and overflow flag are loaded into the output register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its data stable until the
// transfer. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   sync clear of the in-flight product and partial sum
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_last   operands and end-of-group marker
//   out_valid/out_ready   result handshake
//   out_sum               group sum modulo 2**ACC_W
//   out_cnt               number of terms in the group, saturating
//   out_ovf               a carry out of ACC_W occurred in the group
// ----------------------------------------------------------------------------
module vedic_mac4
    import vedic_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic en;        // whole pipeline advances
    logic accept;    // operand pair taken this edge
    logic s2_fire;   // S1 holds a term that S2 consumes this edge

    // S1 registers
    logic              s1_valid;
    logic [PROD_W-1:0] s1_prod;
    logic              s1_last;

    // S2 group state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // Combinational datapath
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum_ext;   // carry in the top bit
    logic [ACC_W-1:0]  sum;
    logic              carry;
    logic [CNT_W-1:0]  cnt_inc;
    logic              grp_ovf;

    // A full output register blocks everything until it is drained, so
    // S1 and S2 never need their own skid storage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !clr;
    assign accept   = in_valid && in_ready;
    assign s2_fire  = en && s1_valid;

    // ------------------------------------------------------------------
    // Multiplier in front of S1
    // ------------------------------------------------------------------
    multiplier4x4 #(
        .N (OP_W)
    ) u_mult (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    // ------------------------------------------------------------------
    // S2 arithmetic
    // ------------------------------------------------------------------
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, s1_prod};
    assign sum     = sum_ext[ACC_W-1:0];
    assign carry   = sum_ext[ACC_W];
    assign grp_ovf = ovf | carry;

    // The term count sticks at its maximum rather than wrapping.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt
                                             : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // S1: registered product
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_last  <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            s1_prod  <= prod;
            s1_last  <= in_last;
        end
    end

    // ------------------------------------------------------------------
    // S2: group accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (s2_fire) begin
            if (s1_last) begin
                // Group closes: restart from zero for the next group.
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= sum;
                cnt <= cnt_inc;
                ovf <= grp_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // clr blocks the load of a closing group but leaves a pending result
    // and its handshake alone. A load on the same edge as a drain keeps
    // out_valid high, giving back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (!clr && s2_fire && s1_last) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_cnt   <= cnt_inc;
            out_ovf   <= grp_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
